vga_text_console: RTL and testbench
===================================

# vga_text_console

Character-stream controller for the 80x30 colour text frame buffer. It accepts one character per valid/ready handshake and decodes control codes. It tracks the cursor and sequences all frame-buffer traffic on the CPU-side port (clk domain): single-cell writes, full-screen clear and one-line scroll-up. It sits between a CPU/UART byte source and the frame buffer's port A, and owns that port exclusively.

## Interface
Parameters:
- BLANK_ATTR, 8'h07: attribute used for cells blanked by clear and scroll.
- BLANK_CHAR, 8'h20: character code used for blanked cells.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- ch_valid  in  1  character present on ch_data/ch_attr.
- ch_data  in  8  character or control code.
- ch_attr  in  8  attribute for a printable character (fg/bg palette indices).
- ch_ready  out  1  block can accept a character this cycle.
- busy  out  1  clear or scroll sequence in progress.
- cursor_col  out  7  current column, 0..79.
- cursor_row  out  5  current row, 0..29.
- fb_en  out  1  frame-buffer port enable.
- fb_we  out  4  byte write enables.
- fb_addr  out  11  word address.
- fb_wdata  out  32  write data.
- fb_rdata  in  32  read data, valid the cycle after a read is issued.

## Operation
- Cell format: 16 bits {attr, char}. Two cells per 32-bit word; the even column is in [15:0] and the odd column in [31:16]. Row r occupies words r*40 .. r*40+39, so the screen uses words 0..1199.
- A transfer is accepted when ch_valid && ch_ready.
- Code decode:
  - 0x0A (LF): col=0, advance row.
  - 0x0D (CR): col=0.
  - 0x08 (BS): if col>0, col=col-1; no erase.
  - 0x0C (FF): clear the screen, cursor to (0,0).
  - Any other code: printable; write cell at the cursor, then advance col.
- Column advance: if col==79, set col=0 and advance row.
- Row advance: if row<29, row=row+1. If row==29, row stays 29 and a scroll starts.
- Cell write: addr=row*40+col[6:1]; wdata={ch_attr,ch_data,ch_attr,ch_data}; fb_we=4'b0011 for an even col, 4'b1100 for an odd col.
- FSM states: IDLE, WRITE, CLEAR, SCROLL_RD, SCROLL_WR, SCROLL_CLR. An 11-bit word counter idx drives the sequences.
  - IDLE: ch_ready=1.
    - Printable -> WRITE.
    - FF -> CLEAR with idx=0.
    - LF at row 29 -> SCROLL_RD with idx=0.
    - Other codes update the cursor and stay in IDLE.
  - WRITE: issue the cell write. Go to SCROLL_RD if the advance wraps past row 29, else IDLE.
  - CLEAR: write the blank word {BLANK_ATTR,BLANK_CHAR} x2 with fb_we=4'hF to idx, one word per cycle. Exit to IDLE after idx==1199.
  - SCROLL_RD: fb_en=1, fb_we=0, addr=idx+40. Next state SCROLL_WR.
  - SCROLL_WR: fb_en=1, fb_we=4'hF, addr=idx, wdata=fb_rdata. Then idx+1; next state SCROLL_RD, or SCROLL_CLR once idx==1159.
  - SCROLL_CLR: write blank words to idx 1160..1199, then IDLE.
- busy=1 in CLEAR/SCROLL_*. ch_ready=0 in every state except IDLE.
- fb_* outputs are registered. fb_en=0 and fb_we=0 in IDLE.

## Timing
- Reset values:
  - state=IDLE, cursor (0,0), idx=0.
  - fb_en=0, fb_we=0, fb_addr=0, fb_wdata=0.
  - busy=0; ch_ready=1 in the first cycle after reset deasserts.
- Reset asserted mid-sequence aborts it immediately. Partially cleared or scrolled contents are left as-is.
- Printable char accepted at cycle T: the write is on the fb_* port at T+1, and the cursor is updated at T+1. ch_ready=0 at T+1 and returns to 1 at T+2, giving 1 char per 2 cycles at most.
- Non-printing codes (CR/BS, and LF with row<29): cursor updated at T+1, ch_ready stays 1.
- CLEAR: 1200 cycles; cursor is (0,0) from T+1.
- Scroll: 2x1160 + 40 = 2360 cycles. The cursor reads (0,29) throughout.
- fb_rdata is sampled in SCROLL_WR, one cycle after its SCROLL_RD. The port is a 1-cycle synchronous-read RAM.
- ch_data is ignored while ch_ready=0. The source must hold ch_valid.

## Structure
- Package vga_text_pkg holds:
  - Constants COLS=80, ROWS=30, WORDS_PER_ROW=40, FB_WORDS=1200.
  - Control-code constants.
  - The state enum.
- One sub-module is natural: vga_cursor, holding the col/row registers, the advance/LF/CR/BS logic and a wrap_out flag.
- The FSM and fb-port driving stay in the top.

## Test plan
- Reset, then 'A' (0x41) with attr 0x1F at (0,0) -> one write: addr 0, fb_we=0011, wdata=1F411F41. Cursor becomes (1,0).
- 'B' at col 1, row 2 -> addr 80, fb_we=1100, cursor (2,2). At col 79, row 5 -> addr 239, cursor (0,6).
- FF -> busy for 1200 cycles, writes 0x07200720 to words 0..1199 with fb_we=F, cursor (0,0), ch_ready low throughout.
- Preload the RAM model with row tags, cursor at row 29, send LF:
  - word i receives the old word i+40;
  - words 1160..1199 are blank;
  - takes 2360 cycles, cursor (0,29).
- BS at col 0 -> no change. CR at (37,4) -> (0,4). Neither produces a write.
- Assert reset mid-scroll -> next cycle fb_en=0, ch_ready=1, cursor (0,0). A following char writes addr 0.

Source files
------------

// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared constants, control codes and state types for the text console
package vga_text_pkg;

   localparam int COLS          = 80;
   localparam int ROWS          = 30;
   localparam int WORDS_PER_ROW = 40;
   localparam int FB_WORDS      = 1200;

   localparam logic [6:0]  LAST_COL         = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW         = 5'(ROWS - 1);
   localparam logic [10:0] ROW_WORDS        = 11'(WORDS_PER_ROW);
   localparam logic [10:0] LAST_WORD        = 11'(FB_WORDS - 1);
   localparam logic [10:0] LAST_SCROLL_WORD = 11'(FB_WORDS - WORDS_PER_ROW - 1);

   localparam logic [7:0] CODE_BS = 8'h08;
   localparam logic [7:0] CODE_LF = 8'h0A;
   localparam logic [7:0] CODE_FF = 8'h0C;
   localparam logic [7:0] CODE_CR = 8'h0D;

   typedef enum logic [2:0] {
      IDLE, WRITE, CLEAR, SCROLL_RD, SCROLL_WR, SCROLL_CLR
   } state_e;

   typedef enum logic [2:0] {
      CUR_NONE, CUR_ADV, CUR_LF, CUR_CR, CUR_BS, CUR_HOME
   } cur_cmd_e;

   // Two cells per word, so the word column is col[6:1].
   function automatic logic [10:0] cell_addr(input logic [4:0] row, input logic [5:0] word_col);
      return ({6'd0, row} << 5) + ({6'd0, row} << 3) + {5'd0, word_col};
   endfunction

endpackage

// File: rtl/vga_text_console_if.sv
// rtl/vga_text_console_if.sv - character stream handshake between byte source and console
interface vga_text_console_if;
   logic       ch_valid;
   logic [7:0] ch_data;
   logic [7:0] ch_attr;
   logic       ch_ready;

   modport master (output ch_valid, ch_data, ch_attr, input ch_ready);
   modport slave  (input ch_valid, ch_data, ch_attr, output ch_ready);
endinterface

// File: rtl/vga_text_console_cursor.sv
// rtl/vga_text_console_cursor.sv - cursor column/row tracking; wrap_out flags the last advance hit row 29
module vga_cursor
   import vga_text_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  cur_cmd_e   cmd,
   output logic [6:0] col,
   output logic [4:0] row,
   output logic       wrap_out
);
   logic [6:0] col_q, col_d;
   logic [4:0] row_q, row_d;
   logic       wrap_q, wrap_d;
   logic       new_line;

   always_comb begin
      col_d    = col_q;
      row_d    = row_q;
      new_line = 1'b0;
      case (cmd)
         CUR_ADV: begin
            if (col_q == LAST_COL) begin
               col_d    = '0;
               new_line = 1'b1;
            end else begin
               col_d = col_q + 7'd1;
            end
         end
         CUR_LF: begin
            col_d    = '0;
            new_line = 1'b1;
         end
         CUR_CR: col_d = '0;
         CUR_BS: if (col_q != '0) col_d = col_q - 7'd1;
         CUR_HOME: begin
            col_d = '0;
            row_d = '0;
         end
         default: ;
      endcase
      // The bottom row never moves; the controller scrolls the contents instead.
      wrap_d = new_line && (row_q == LAST_ROW);
      if (new_line && (row_q != LAST_ROW)) row_d = row_q + 5'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q  <= '0;
         row_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         wrap_q <= wrap_d;
      end
   end

   assign col      = col_q;
   assign row      = row_q;
   assign wrap_out = wrap_q;
endmodule

// File: rtl/vga_text_console.sv
// rtl/vga_text_console.sv - character stream decoder and frame-buffer port sequencer
module vga_text_console
   import vga_text_pkg::*;
#(
   parameter logic [7:0] BLANK_ATTR = 8'h07,
   parameter logic [7:0] BLANK_CHAR = 8'h20
) (
   input  logic                     clk,
   input  logic                     reset,
   vga_text_console_if.slave        ch,
   output logic                     busy,
   output logic [6:0]               cursor_col,
   output logic [4:0]               cursor_row,
   output logic                     fb_en,
   output logic [3:0]               fb_we,
   output logic [10:0]              fb_addr,
   output logic [31:0]              fb_wdata,
   input  logic [31:0]              fb_rdata
);
   localparam logic [31:0] BLANK_WORD = {BLANK_ATTR, BLANK_CHAR, BLANK_ATTR, BLANK_CHAR};

   state_e      state_q, state_d;
   logic [10:0] idx_q, idx_d;
   logic        fb_en_q, fb_en_d;
   logic [3:0]  fb_we_q, fb_we_d;
   logic [10:0] fb_addr_q, fb_addr_d;
   logic [31:0] fb_wdata_q, fb_wdata_d;
   cur_cmd_e    cur_cmd;
   logic        wrap;

   vga_cursor u_cursor (
      .clk      (clk),
      .reset    (reset),
      .cmd      (cur_cmd),
      .col      (cursor_col),
      .row      (cursor_row),
      .wrap_out (wrap)
   );

   // Each state computes the port operation presented on the following cycle.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cur_cmd    = CUR_NONE;
      fb_en_d    = 1'b0;
      fb_we_d    = 4'h0;
      fb_addr_d  = fb_addr_q;
      fb_wdata_d = fb_wdata_q;
      case (state_q)
         IDLE: begin
            if (ch.ch_valid) begin
               case (ch.ch_data)
                  CODE_LF: begin
                     cur_cmd = CUR_LF;
                     if (cursor_row == LAST_ROW) begin
                        state_d = SCROLL_RD;
                        idx_d   = '0;
                     end
                  end
                  CODE_CR: cur_cmd = CUR_CR;
                  CODE_BS: cur_cmd = CUR_BS;
                  CODE_FF: begin
                     cur_cmd = CUR_HOME;
                     state_d = CLEAR;
                     idx_d   = '0;
                  end
                  default: begin
                     cur_cmd    = CUR_ADV;
                     state_d    = WRITE;
                     fb_en_d    = 1'b1;
                     fb_we_d    = cursor_col[0] ? 4'b1100 : 4'b0011;
                     fb_addr_d  = cell_addr(cursor_row, cursor_col[6:1]);
                     fb_wdata_d = {2{ch.ch_attr, ch.ch_data}};
                  end
               endcase
            end
         end
         WRITE: begin
            state_d = IDLE;
            if (wrap) begin
               state_d = SCROLL_RD;
               idx_d   = '0;
            end
         end
         CLEAR, SCROLL_CLR: begin
            fb_en_d    = 1'b1;
            fb_we_d    = 4'hF;
            fb_addr_d  = idx_q;
            fb_wdata_d = BLANK_WORD;
            if (idx_q == LAST_WORD) state_d = IDLE;
            else                    idx_d   = idx_q + 11'd1;
         end
         SCROLL_RD: begin
            fb_en_d   = 1'b1;
            fb_addr_d = idx_q + ROW_WORDS;
            state_d   = SCROLL_WR;
         end
         SCROLL_WR: begin
            fb_en_d    = 1'b1;
            fb_we_d    = 4'hF;
            fb_addr_d  = idx_q;
            fb_wdata_d = fb_rdata;
            idx_d      = idx_q + 11'd1;
            state_d    = (idx_q == LAST_SCROLL_WORD) ? SCROLL_CLR : SCROLL_RD;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         fb_en_q    <= 1'b0;
         fb_we_q    <= 4'h0;
         fb_addr_q  <= '0;
         fb_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         fb_en_q    <= fb_en_d;
         fb_we_q    <= fb_we_d;
         fb_addr_q  <= fb_addr_d;
         fb_wdata_q <= fb_wdata_d;
      end
   end

   assign ch.ch_ready = (state_q == IDLE);
   assign busy        = (state_q == CLEAR) || (state_q == SCROLL_RD) ||
                        (state_q == SCROLL_WR) || (state_q == SCROLL_CLR);
   assign fb_en       = fb_en_q;
   assign fb_we       = fb_we_q;
   assign fb_addr     = fb_addr_q;
   assign fb_wdata    = fb_wdata_q;
endmodule

// File: tb/tb_vga_text_console.sv
// tb/tb_vga_text_console.sv - scoreboard bench for vga_text_console
module tb_vga_text_console;
   typedef struct packed {
      logic [10:0] addr;
      logic [3:0]  we;
      logic [31:0] data;
   } wr_t;

   localparam logic [31:0] BLANK = 32'h07200720;

   logic        clk = 1'b0;
   logic        reset;
   logic        busy;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic        fb_en;
   logic [3:0]  fb_we;
   logic [10:0] fb_addr;
   logic [31:0] fb_wdata;
   logic [31:0] fb_rdata;
   logic [31:0] mem [0:2047];
   logic [31:0] shadow [0:1199];
   logic        preload_req = 1'b0;
   wr_t         exp_q [$];
   int          tests = 0;
   int          fails = 0;

   vga_text_console_if cif ();

   vga_text_console dut (
      .clk        (clk),
      .reset      (reset),
      .ch         (cif),
      .busy       (busy),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .fb_en      (fb_en),
      .fb_we      (fb_we),
      .fb_addr    (fb_addr),
      .fb_wdata   (fb_wdata),
      .fb_rdata   (fb_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] tag(input int i);
      return {8'(i / 40), 8'h5A, 16'(i)};
   endfunction

   // RAM model: the registered port address is the RAM's address register.
   assign fb_rdata = mem[fb_addr];

   always @(posedge clk) begin
      if (preload_req) begin
         for (int i = 0; i < 2048; i++) mem[i] <= (i < 1200) ? tag(i) : 32'h0;
      end else if (fb_en === 1'b1) begin
         for (int b = 0; b < 4; b++)
            if (fb_we[b]) mem[fb_addr][8*b +: 8] <= fb_wdata[8*b +: 8];
      end
   end

   task automatic push_exp(input logic [10:0] a, input logic [3:0] we, input logic [31:0] d);
      exp_q.push_back({a, we, d});
      for (int b = 0; b < 4; b++)
         if (we[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic push_cell(input int row, input int col, input logic [7:0] d, input logic [7:0] a);
      push_exp(11'(row * 40 + col / 2), (col % 2 == 1) ? 4'b1100 : 4'b0011, {a, d, a, d});
   endtask

   task automatic tick();
      wr_t e;
      @(posedge clk);
      #1;
      if (fb_en === 1'b1 && fb_we !== 4'h0) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write addr=%0d we=%b data=%h required no write", fb_addr, fb_we, fb_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({fb_addr, fb_we, fb_wdata} !== e) begin
               fails++;
               $display("FAIL fb_write got addr=%0d we=%b data=%h required addr=%0d we=%b data=%h",
                        fb_addr, fb_we, fb_wdata, e.addr, e.we, e.data);
            end
         end
      end
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] a);
      int n = 0;
      cif.ch_valid = 1'b1;
      cif.ch_data  = d;
      cif.ch_attr  = a;
      while (cif.ch_ready !== 1'b1 && n < 6000) begin
         tick();
         n++;
      end
      if (n >= 6000) begin
         tests++;
         fails++;
         $display("FAIL send_timeout ready=%b required 1", cif.ch_ready);
      end
      tick();
      cif.ch_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      cif.ch_valid = 1'b0;
      cif.ch_data  = 8'h00;
      cif.ch_attr  = 8'h00;
      repeat (3) tick();
      reset = 1'b0;
      tests++;
      if ({fb_en, fb_we, fb_addr, fb_wdata} !== 48'h0) begin
         fails++;
         $display("FAIL reset_fb got en=%b we=%b addr=%0d data=%h required all 0", fb_en, fb_we, fb_addr, fb_wdata);
      end
      tests++;
      if (busy !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
         fails++;
         $display("FAIL reset_state got busy=%b col=%0d row=%0d required 0 0 0", busy, cursor_col, cursor_row);
      end
      tick();
      tests++;
      if (cif.ch_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready got %b required 1", cif.ch_ready);
      end
   endtask

   task automatic test_printable();
      push_exp(11'd0, 4'b0011, 32'h1F411F41);
      send(8'h41, 8'h1F);
      tests++;
      if (fb_en !== 1'b1 || cif.ch_ready !== 1'b0) begin
         fails++;
         $display("FAIL printable_t1 got en=%b ready=%b required 1 0", fb_en, cif.ch_ready);
      end
      tests++;
      if (cursor_col !== 7'd1 || cursor_row !== 5'd0) begin
         fails++;
         $display("FAIL printable_cursor got %0d,%0d required 1,0", cursor_col, cursor_row);
      end
      tick();
      tests++;
      if (cif.ch_ready !== 1'b1 || fb_en !== 1'b0) begin
         fails++;
         $display("FAIL printable_t2 got ready=%b en=%b required 1 0", cif.ch_ready, fb_en);
      end
   endtask

   task automatic test_positioning();
      logic [7:0] d;
      send(8'h0A, 8'h00);
      tests++;
      if (cif.ch_ready !== 1'b1 || cursor_col !== 7'd0 || cursor_row !== 5'd1) begin
         fails++;
         $display("FAIL lf_advance got ready=%b %0d,%0d required 1 0,1", cif.ch_ready, cursor_col, cursor_row);
      end
      send(8'h0A, 8'h00);
      push_exp(11'd80, 4'b0011, 32'h70787078);
      send(8'h78, 8'h70);
      push_exp(11'd80, 4'b1100, 32'h2E422E42);
      send(8'h42, 8'h2E);
      tests++;
      if (cursor_col !== 7'd2 || cursor_row !== 5'd2) begin
         fails++;
         $display("FAIL odd_col_cursor got %0d,%0d required 2,2", cursor_col, cursor_row);
      end
      repeat (3) send(8'h0A, 8'h00);
      for (int c = 0; c < 79; c++) begin
         d = 8'h30 + 8'(c % 10);
         push_cell(5, c, d, 8'h1E);
         send(d, 8'h1E);
      end
      push_exp(11'd239, 4'b1100, 32'h4A5A4A5A);
      send(8'h5A, 8'h4A);
      tests++;
      if (cursor_col !== 7'd0 || cursor_row !== 5'd6) begin
         fails++;
         $display("FAIL col79_wrap got %0d,%0d required 0,6", cursor_col, cursor_row);
      end
      tick();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL positioning_drain got %0d pending required 0", exp_q.size());
      end
   endtask

   task automatic test_clear();
      int cnt = 0;
      int bad = 0;
      for (int i = 0; i < 1200; i++) push_exp(11'(i), 4'hF, BLANK);
      send(8'h0C, 8'h00);
      tests++;
      if (busy !== 1'b1 || cif.ch_ready !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
         fails++;
         $display("FAIL clear_start got busy=%b ready=%b %0d,%0d required 1 0 0,0", busy, cif.ch_ready, cursor_col, cursor_row);
      end
      while (busy === 1'b1 && cnt < 3000) begin
         if (cif.ch_ready !== 1'b0) bad++;
         cnt++;
         tick();
      end
      tests++;
      if (cnt != 1200) begin
         fails++;
         $display("FAIL clear_cycles got %0d required 1200", cnt);
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL clear_ready got %0d ready cycles required 0", bad);
      end
      tests++;
      if (exp_q.size() != 0 || cif.ch_ready !== 1'b1) begin
         fails++;
         $display("FAIL clear_done got %0d pending ready=%b required 0 1", exp_q.size(), cif.ch_ready);
      end
   endtask

   task automatic test_bs_cr();
      send(8'h08, 8'h00);
      tests++;
      if (fb_en !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
         fails++;
         $display("FAIL bs_col0 got en=%b %0d,%0d required 0 0,0", fb_en, cursor_col, cursor_row);
      end
      repeat (4) send(8'h0A, 8'h00);
      for (int c = 0; c < 37; c++) begin
         push_cell(4, c, 8'h61, 8'h05);
         send(8'h61, 8'h05);
      end
      tick();
      tests++;
      if (cursor_col !== 7'd37 || cursor_row !== 5'd4) begin
         fails++;
         $display("FAIL bs_cr_setup got %0d,%0d required 37,4", cursor_col, cursor_row);
      end
      send(8'h0D, 8'h00);
      tests++;
      if (fb_en !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd4) begin
         fails++;
         $display("FAIL cr got en=%b %0d,%0d required 0 0,4", fb_en, cursor_col, cursor_row);
      end
      push_cell(4, 0, 8'h6B, 8'h05);
      send(8'h6B, 8'h05);
      send(8'h08, 8'h00);
      tests++;
      if (fb_en !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd4) begin
         fails++;
         $display("FAIL bs_dec got en=%b %0d,%0d required 0 0,4", fb_en, cursor_col, cursor_row);
      end
      tick();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL bs_cr_drain got %0d pending required 0", exp_q.size());
      end
   endtask

   task automatic test_scroll();
      int cnt = 0;
      int bad = 0;
      repeat (25) send(8'h0A, 8'h00);
      tests++;
      if (cursor_col !== 7'd0 || cursor_row !== 5'd29) begin
         fails++;
         $display("FAIL scroll_setup got %0d,%0d required 0,29", cursor_col, cursor_row);
      end
      preload_req = 1'b1;
      tick();
      preload_req = 1'b0;
      for (int i = 0; i < 1200; i++) shadow[i] = tag(i);
      for (int i = 0; i < 1160; i++) push_exp(11'(i), 4'hF, shadow[i + 40]);
      for (int i = 1160; i < 1200; i++) push_exp(11'(i), 4'hF, BLANK);
      send(8'h0A, 8'h00);
      while (busy === 1'b1 && cnt < 6000) begin
         if (cursor_col !== 7'd0 || cursor_row !== 5'd29 || cif.ch_ready !== 1'b0) bad++;
         cnt++;
         tick();
      end
      tests++;
      if (cnt != 2360) begin
         fails++;
         $display("FAIL scroll_cycles got %0d required 2360", cnt);
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL scroll_cursor got %0d bad cycles required 0", bad);
      end
      tests++;
      if (exp_q.size() != 0 || cif.ch_ready !== 1'b1) begin
         fails++;
         $display("FAIL scroll_done got %0d pending ready=%b required 0 1", exp_q.size(), cif.ch_ready);
      end
   endtask

   task automatic test_wrap_reset();
      for (int c = 0; c < 79; c++) begin
         push_cell(29, c, 8'h2A, 8'h3C);
         send(8'h2A, 8'h3C);
      end
      push_cell(29, 79, 8'h57, 8'h3C);
      for (int i = 0; i < 1160; i++) push_exp(11'(i), 4'hF, shadow[i + 40]);
      for (int i = 1160; i < 1200; i++) push_exp(11'(i), 4'hF, BLANK);
      send(8'h57, 8'h3C);
      tests++;
      if (cursor_col !== 7'd0 || cursor_row !== 5'd29 || cif.ch_ready !== 1'b0) begin
         fails++;
         $display("FAIL wrap_write got %0d,%0d ready=%b required 0,29 0", cursor_col, cursor_row, cif.ch_ready);
      end
      tick();
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL wrap_scroll_start got busy=%b required 1", busy);
      end
      repeat (600) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests++;
      if (fb_en !== 1'b0 || cif.ch_ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL abort_port got en=%b ready=%b busy=%b required 0 1 0", fb_en, cif.ch_ready, busy);
      end
      tests++;
      if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
         fails++;
         $display("FAIL abort_cursor got %0d,%0d required 0,0", cursor_col, cursor_row);
      end
      exp_q.delete();
      push_exp(11'd0, 4'b0011, 32'h11511151);
      send(8'h51, 8'h11);
      tick();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL abort_next_char got %0d pending required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_printable();
      test_positioning();
      test_clear();
      test_bs_cr();
      test_scroll();
      test_wrap_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
